// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit period.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to RESET_VAL.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, FIFO write pulse, framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       fifo_full,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy,
    output logic [2:0] state
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_rx_state_t   state_q, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       idx, idx_next;
    logic [7:0]       shreg, shreg_next;
    logic [7:0]       data_next;
    logic             valid_next, ferr_next, ovr_next;
    logic             rxs;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxs)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_next;
            cnt       <= cnt_next;
            idx       <= idx_next;
            shreg     <= shreg_next;
            rx_data   <= data_next;
            rx_valid  <= valid_next;
            frame_err <= ferr_next;
            overrun   <= ovr_next;
        end
    end

    always_comb begin
        state_next = state_q;
        cnt_next   = cnt;
        idx_next   = idx;
        shreg_next = shreg;
        data_next  = rx_data;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        ovr_next   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt == MID) begin
                    if (rxs) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        cnt_next   = '0;
                        idx_next   = '0;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_next   = '0;
                    shreg_next = {rxs, shreg[7:1]};
                    if (idx == 3'd7) state_next = STOP;
                    else             idx_next   = idx + 3'd1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                // fifo_full only matters here, in the single stop-sample cycle
                if (cnt == LAST) begin
                    cnt_next = '0;
                    if (!rxs) begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end else if (fifo_full) begin
                        ovr_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        valid_next = 1'b1;
                        data_next  = shreg;
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            BREAK: begin
                if (rxs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames in, FIFO/error pulses checked against an expected queue.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 10;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic       fifo_full;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc;
    int valid_cyc[$];
    // entry = {kind, rx_data}; kind 1 = rx_valid, 2 = frame_err, 3 = overrun
    logic [9:0] exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .fifo_full (fifo_full),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy),
        .state     (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #2 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_bit(input logic b, input logic full);
        rxd       = b;
        fifo_full = full;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit,
                             input logic full_data, input logic full_stop);
        start_cyc = cyc;
        drive_bit(1'b0, full_data);
        for (int i = 0; i < 8; i++) drive_bit(d[i], full_data);
        drive_bit(stop_bit, full_stop);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && (rx_valid || frame_err || overrun)) begin
            logic [9:0] obs;
            check("pulse_exclusive", 32'($countones({rx_valid, frame_err, overrun})), 32'd1);
            obs = {(rx_valid ? 2'd1 : (frame_err ? 2'd2 : 2'd3)), rx_data};
            if (exp_q.size() == 0) check("unexpected_pulse", 32'(obs), 32'd0);
            else                   check("pulse", 32'(obs), 32'(exp_q.pop_front()));
            if (rx_valid) valid_cyc.push_back(cyc);
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n     = 1'b0;
        rxd       = 1'b1;
        fifo_full = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_rx_data",   32'(rx_data),   32'h00);
        check("rst_rx_valid",  32'(rx_valid),  32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_state",     32'(state),     32'(IDLE));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // single frame 0x2D, latency from rxd fall to rx_valid
        valid_cyc.delete();
        exp_q.push_back({2'd1, 8'h2D});
        send_byte(8'h2D, 1'b1, 1'b0, 1'b0);
        wait_drain("drain_2d");
        check("lat_count", 32'(valid_cyc.size()), 32'd1);
        if (valid_cyc.size() == 1) check("latency", 32'(valid_cyc[0] - start_cyc), 32'd98);

        // back-to-back 0x2D then 0x0F
        valid_cyc.delete();
        exp_q.push_back({2'd1, 8'h2D});
        exp_q.push_back({2'd1, 8'h0F});
        send_byte(8'h2D, 1'b1, 1'b0, 1'b0);
        send_byte(8'h0F, 1'b1, 1'b0, 1'b0);
        wait_drain("drain_b2b");
        check("b2b_count", 32'(valid_cyc.size()), 32'd2);
        if (valid_cyc.size() == 2) check("b2b_spacing", 32'(valid_cyc[1] - valid_cyc[0]), 32'd100);

        // 0xAA with low stop bit, line held low: frame error then BREAK
        exp_q.push_back({2'd2, 8'h0F});
        send_byte(8'hAA, 1'b0, 1'b0, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        check("break_busy",  32'(busy),  32'd1);
        check("break_state", 32'(state), 32'(BREAK));
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        check("break_exit_busy",  32'(busy),  32'd0);
        check("break_exit_state", 32'(state), 32'(IDLE));
        check("break_data_hold",  32'(rx_data), 32'h0F);
        wait_drain("drain_ferr");

        // 3-cycle glitch: enters START, falls back to IDLE with no pulse
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        check("glitch_start", 32'(state), 32'(START));
        repeat (20) @(negedge clk);
        check("glitch_idle", 32'(state), 32'(IDLE));
        check("glitch_busy", 32'(busy),  32'd0);

        // overrun: fifo_full only during the stop bit of 0x55
        exp_q.push_back({2'd3, 8'h0F});
        send_byte(8'h55, 1'b1, 1'b0, 1'b1);
        fifo_full = 1'b0;
        wait_drain("drain_ovr");
        check("ovr_data_hold", 32'(rx_data), 32'h0F);

        // fifo_full high during data bits only is ignored
        exp_q.push_back({2'd1, 8'h81});
        send_byte(8'h81, 1'b1, 1'b1, 1'b0);
        wait_drain("drain_81");
        check("full_ignored_data", 32'(rx_data), 32'h81);

        // reset during data bit 4 of 0xF0 (remaining bits all high)
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
        rxd = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_rx_data",  32'(rx_data), 32'h00);
        check("midrst_outputs",  32'({rx_valid, frame_err, overrun, busy}), 32'd0);
        check("midrst_state",    32'(state), 32'(IDLE));
        rst_n = 1'b1;
        repeat (5 * CPB) @(negedge clk);
        check("postrst_state", 32'(state), 32'(IDLE));
        check("postrst_data",  32'(rx_data), 32'h00);
        exp_q.push_back({2'd1, 8'h3C});
        send_byte(8'h3C, 1'b1, 1'b0, 1'b0);
        wait_drain("drain_3c");
        check("postrst_3c", 32'(rx_data), 32'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
